// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Owner and state encodings are shared by the top module and the winner picker.
package mem_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam int BE_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Purely combinational winner selection between fetch and data requesters.
// Fixed data-over-fetch priority by default; alternating priority when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_winner,
  output logic       any_req,
  output arb_owner_t winner
);

  logic d_pref;

`ifdef MEM_ARB_RR_EN
  // On contention, the requester that lost last time goes first.
  assign d_pref = (last_winner == OWN_IF);
`else
  logic unused_last_winner;
  assign unused_last_winner = (last_winner == OWN_D);
  assign d_pref             = 1'b1;
`endif

  assign any_req = if_req | d_req;
  assign winner  = (d_req & (~if_req | d_pref)) ? OWN_D : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages, one transaction outstanding.
// Grants are combinational and may turn around on the response cycle; MEM_ARB_RR_EN selects alternating priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       last_q;
  arb_owner_t       winner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             any_req, busy, grant;

  arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_winner (last_q),
    .any_req     (any_req),
    .winner      (winner)
  );

  assign busy  = (state_q == BUSY);
  assign grant = any_req & (~busy | mem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)      last_q <= OWN_IF;
    else if (grant) last_q <= winner;
  end
`else
  assign last_q = OWN_IF;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (grant) begin
      state_d = BUSY;
      owner_d = winner;
      cnt_d   = '0;
    end else if (busy) begin
      if (mem_rvalid) begin
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        // Abandon the transaction silently; a late response lands in IDLE and is dropped.
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Every output is forced low while reset is held, even mid-transaction.
  always_comb begin
    if_gnt      = ~reset & grant & (winner == OWN_IF);
    d_gnt       = ~reset & grant & (winner == OWN_D);
    if_rvalid   = ~reset & busy & mem_rvalid & (owner_q == OWN_IF);
    d_rvalid    = ~reset & busy & mem_rvalid & (owner_q == OWN_D);
    if_rdata    = (~reset & busy & mem_rvalid) ? mem_rdata : '0;
    d_rdata     = (~reset & busy & mem_rvalid) ? mem_rdata : '0;
    mem_req     = if_gnt | d_gnt;
    mem_we      = d_gnt & d_we;
    // Instruction fetches always read the full word.
    mem_be      = d_gnt ? d_be : (if_gnt ? {BE_W{1'b1}} : '0);
    mem_addr    = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    mem_wdata   = d_gnt ? d_wdata : '0;
    stall_f     = ~reset & ((if_req & ~if_gnt) | (busy & (owner_q == OWN_IF) & ~mem_rvalid));
    stall_m     = ~reset & ((d_req & ~d_gnt) | (busy & (owner_q == OWN_D) & ~mem_rvalid));
    err_timeout = ~reset & err_q;
  end

endmodule
